ahfp_ci_issuer: RTL and testbench

Initiator side of the fixed-latency floating-point custom-instruction datapath (ahfp_* units). It accepts single-precision operand pairs on a valid/ready stream, drives them into an attached fully pipelined, reset-less FP unit, tracks in-flight operations with a valid shift register, and buffers returning results in a FIFO for a valid/ready result stream. Credit-based issue guarantees the FIFO cannot overflow, so results are never dropped when the consumer stalls.

---
 rtl/ahfp_ci_issuer.sv | 130 +++++++++++++
 tb/tb_ahfp_ci_issuer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahfp_ci_issuer.sv
// rtl/ahfp_ci_issuer.sv - issue/collect front end for a fixed-latency pipelined FP custom-instruction unit
//
// Purpose: accepts operand pairs on a valid/ready stream, registers them into
// an attached reset-less FP pipeline, tracks in-flight ops with a valid shift
// register, and buffers returning results in a FIFO feeding a valid/ready
// result stream. Issue is credit-limited so the FIFO can never overflow.
//
// Optional feature macro: AHFP_CI_STATS_EN (adds the issued_count port).
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready     operand stream handshake; in_a/in_b operands
//   fpu_dataa/fpu_datab   registered operands to the FP unit
//   fpu_result            FP unit result, valid LATENCY cycles after sampling
//   out_valid/out_ready   result stream handshake; out_data = FIFO head
//   busy                  any operation in flight or buffered
//   issued_count          (AHFP_CI_STATS_EN only) saturating issue counter
module ahfp_ci_issuer #(
   parameter int LATENCY = 7,
   parameter int DEPTH   = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic [31:0] fpu_dataa,
   output logic [31:0] fpu_datab,
   input  logic [31:0] fpu_result,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        busy
`ifdef AHFP_CI_STATS_EN
   ,
   output logic [31:0] issued_count
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0]    outstanding_q, outstanding_d;
   logic [LATENCY:0] vld_q, vld_d;
   logic [31:0]      dataa_q, dataa_d;
   logic [31:0]      datab_q, datab_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [31:0]      mem_q [DEPTH];

   logic issue, push, pop, empty, full;

   // Credit check uses only the registered counter, so out_ready never
   // reaches in_ready combinationally.
   assign in_ready  = !reset && (outstanding_q < PW'(DEPTH));
   assign issue     = in_valid && in_ready;
   assign push      = vld_q[LATENCY];
   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign full      = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign out_valid = !empty;
   assign pop       = out_valid && out_ready;
   assign out_data  = mem_q[rd_ptr_q[AW-1:0]];
   assign busy      = (outstanding_q != '0);
   assign fpu_dataa = dataa_q;
   assign fpu_datab = datab_q;

   always_comb begin
      outstanding_d = outstanding_q;
      dataa_d       = dataa_q;
      datab_d       = datab_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      vld_d         = {vld_q[LATENCY-1:0], issue};
      if (issue) begin
         dataa_d = in_a;
         datab_d = in_b;
      end
      case ({issue, pop})
         2'b10:   outstanding_d = outstanding_q + PW'(1);
         2'b01:   outstanding_d = outstanding_q - PW'(1);
         default: outstanding_d = outstanding_q;
      endcase
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         outstanding_q <= '0;
         vld_q         <= '0;
         dataa_q       <= '0;
         datab_q       <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
      end else begin
         outstanding_q <= outstanding_d;
         vld_q         <= vld_d;
         dataa_q       <= dataa_d;
         datab_q       <= datab_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
      end
   end

   // Result storage is intentionally not reset; the pointers define validity.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= fpu_result;
   end

`ifdef AHFP_CI_STATS_EN
   logic [31:0] issued_count_q, issued_count_d;

   always_comb begin
      issued_count_d = issued_count_q;
      if (issue && (issued_count_q != 32'hFFFF_FFFF)) issued_count_d = issued_count_q + 32'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) issued_count_q <= '0;
      else       issued_count_q <= issued_count_d;
   end

   assign issued_count = issued_count_q;
`endif

   // Credits guarantee occupancy + in-flight never exceeds DEPTH.
   a_no_push_at_full: assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: tb/tb_ahfp_ci_issuer.sv
// tb/tb_ahfp_ci_issuer.sv - self-checking bench for ahfp_ci_issuer
module tb_ahfp_ci_issuer;
   localparam int LATENCY = 7;
   localparam int DEPTH   = 16;
   localparam int NV      = 8;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic [31:0] fpu_dataa, fpu_datab, fpu_result;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic        busy;
`ifdef AHFP_CI_STATS_EN
   logic [31:0] issued_count;
`endif

   vec_t        tbl [NV];
   logic [31:0] pipe [LATENCY];
   logic [31:0] sb [$];
   int          pop_cycs [$];
   int          checks = 0, errors = 0;
   int          cyc = 0, n_issue = 0, n_pop = 0, n_ovalid = 0;

   always #5 clk = ~clk;

   ahfp_ci_issuer #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .fpu_dataa(fpu_dataa), .fpu_datab(fpu_datab),
      .fpu_result(fpu_result), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .busy(busy)
`ifdef AHFP_CI_STATS_EN
      , .issued_count(issued_count)
`endif
   );

   // FP unit stand-in: exact subtraction results for the table pairs, an
   // arbitrary mixing function otherwise.
   function automatic logic [31:0] fmodel(input logic [31:0] a, input logic [31:0] b);
      for (int i = 0; i < NV; i++)
         if (tbl[i].a == a && tbl[i].b == b) return tbl[i].exp;
      return a ^ {b[15:0], b[31:16]};
   endfunction

   // Reset-less LATENCY-stage pipeline; first stage samples the operand registers.
   always @(posedge clk) begin
      pipe[0] <= fmodel(fpu_dataa, fpu_datab);
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
   end
   assign fpu_result = pipe[LATENCY-1];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: inputs change just after posedge, so at negedge the
   // handshakes that the next rising edge will take are already visible.
   always @(negedge clk) begin
      cyc++;
      if (out_valid) n_ovalid++;
      if (reset) begin
         sb.delete();
      end else begin
         if (in_valid && in_ready) begin
            sb.push_back(fmodel(in_a, in_b));
            n_issue++;
         end
         if (out_valid && out_ready) begin
            n_pop++;
            pop_cycs.push_back(cyc);
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_underflow: got %h expected none", out_data);
            end else begin
               chk("sb_order", out_data, sb.pop_front());
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   initial begin
      int n, low_cnt, base_i, base_p, base_o;

      tbl[0] = '{32'h40400000, 32'h3F800000, 32'h40000000};
      tbl[1] = '{32'h3F800000, 32'h3F800000, 32'h00000000};
      tbl[2] = '{32'h40000000, 32'h3F000000, 32'h3FC00000};
      tbl[3] = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000};
      tbl[4] = '{32'h40A00000, 32'h40000000, 32'h40400000};
      tbl[5] = '{32'h00000001, 32'h00000000, 32'h00000001};
      tbl[6] = '{32'h3F800000, 32'h40000000, 32'hBF800000};
      tbl[7] = '{32'h41200000, 32'h40800000, 32'h40C00000};

      // Reset state
      tick();
      tick();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_dataa", fpu_dataa, 0);
      chk("rst_datab", fpu_datab, 0);
      reset = 1'b0;
      tick();
      chk("post_rst_in_ready", in_ready, 1);
`ifdef AHFP_CI_STATS_EN
      chk("rst_issued_count", issued_count, 0);
`endif

      // Table: one op at a time, checking latency, data and busy span
      for (int i = 0; i < NV; i++) begin
         in_a = tbl[i].a;
         in_b = tbl[i].b;
         in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         chk("vec_busy_inflight", busy, 1);
         n = 0;
         while (!out_valid && n < 20) begin
            tick();
            n++;
         end
         chk("vec_latency", n, LATENCY + 1);
         chk("vec_data", out_data, tbl[i].exp);
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         chk("vec_busy_after_pop", busy, 0);
         chk("vec_out_valid_after_pop", out_valid, 0);
      end

      // 20 back-to-back ops with out_ready held high
      do_reset();
      out_ready = 1'b1;
      base_p = n_pop;
      pop_cycs.delete();
      low_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         in_a = $urandom;
         in_b = $urandom;
         in_valid = 1'b1;
         if (!in_ready) low_cnt++;
         tick();
      end
      in_valid = 1'b0;
      n = 0;
      while ((n_pop - base_p) < 20 && n < 40) begin
         tick();
         n++;
      end
      chk("b2b_in_ready_low", low_cnt, 0);
      chk("b2b_pops", n_pop - base_p, 20);
      if (pop_cycs.size() == 20) chk("b2b_pop_span", pop_cycs[19] - pop_cycs[0], 19);
      else chk("b2b_pop_cycles", pop_cycs.size(), 20);
      chk("b2b_busy_end", busy, 0);
`ifdef AHFP_CI_STATS_EN
      chk("b2b_issued_count", issued_count, 20);
`endif

      // Fill to DEPTH with the consumer stalled, then pop and issue together
      do_reset();
`ifdef AHFP_CI_STATS_EN
      chk("rst_issued_count_clear", issued_count, 0);
`endif
      base_i = n_issue;
      base_p = n_pop;
      in_valid = 1'b1;
      for (int i = 0; i < 34; i++) begin
         in_a = $urandom;
         in_b = $urandom;
         tick();
      end
      chk("fill_issues", n_issue - base_i, DEPTH);
      chk("fill_in_ready", in_ready, 0);
      chk("fill_out_valid", out_valid, 1);
      chk("fill_busy", busy, 1);
      base_i = n_issue;
      out_ready = 1'b1;
      tick();
      chk("full_pop_no_issue", n_issue - base_i, 0);
      chk("full_pop_in_ready_next", in_ready, 1);
      tick();
      chk("full_next_issue", n_issue - base_i, 1);
      in_valid = 1'b0;
      n = 0;
      while ((busy || out_valid) && n < 60) begin
         tick();
         n++;
      end
      chk("fill_drain_pops", n_pop - base_p, DEPTH + 1);
      chk("fill_drain_busy", busy, 0);

      // Reset while ops are in flight
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_a = $urandom;
         in_b = $urandom;
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_busy", busy, 0);
      tick();
      reset = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready_release", in_ready, 1);
      base_o = n_ovalid;
      for (int i = 0; i < 20; i++) tick();
      chk("midrst_no_results", n_ovalid - base_o, 0);
      chk("midrst_busy_after", busy, 0);
      chk("sb_empty_end", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
